// File: rtl/hdlverifier_jtag_cmd_shifter.sv
// hdlverifier_jtag_cmd_shifter: turns JTAG user-DR scans into single register-bank accesses and returns read data/status on TDO.
// Latency: write strobe in the cycle after Update-DR; rdata sampled READ_LATENCY+1 tck edges after Update-DR.
// Backpressure: none toward the TAP; an Update-DR while busy is dropped and flagged in the sticky ovr status bit.
// Option: define HDLVERIFIER_JTAG_PARITY_EN to append an even-parity MSB to every command frame.
module hdlverifier_jtag_cmd_shifter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  tck,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  tdi,
  output logic                  tdo,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

`ifdef HDLVERIFIER_JTAG_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Command portion of the frame (wr, addr, data) and full scan length.
  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int F     = CMD_W + PAR_BITS;
  localparam int CNT_W = 4;

  // Status word needs rd_valid/err/ovr above the data, so the frame must be at least DATA_WIDTH+3 long.
  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("ADDR_WIDTH must be at least 2 so the status bits fit in the frame");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
    $error("READ_LATENCY must be in 1..15");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [F-1:0]          sr;
  logic [F-1:0]          cap_word;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic                  rd_valid;
  logic                  err;
  logic                  ovr;
  cmd_t                  cmd;
  logic                  par_ok;

  // Qualified strobes; update wins over capture, capture wins over shift.
  logic upd;
  logic cap;
  logic shf;

  // FSM decisions consumed by the datapath.
  logic acc_wr;
  logic acc_rd;
  logic drop;
  logic par_bad;
  logic rd_done;

  assign upd = sel & update_dr;
  assign cap = sel & capture_dr & ~update_dr;
  assign shf = sel & shift_dr & ~update_dr & ~capture_dr;

  assign cmd = sr[CMD_W-1:0];
  assign tdo = sr[0];

`ifdef HDLVERIFIER_JTAG_PARITY_EN
  // Even parity: the parity MSB makes the XOR of the whole frame zero.
  assign par_ok = ~(^sr);
`else
  assign par_ok = 1'b1;
`endif

  // Status word loaded into the shift register on Capture-DR.
  always_comb begin
    cap_word               = '0;
    cap_word[DATA_WIDTH-1:0] = rd_buf;
    cap_word[DATA_WIDTH]   = rd_valid;
    cap_word[DATA_WIDTH+1] = err;
    cap_word[DATA_WIDTH+2] = ovr;
  end

  // FSM state and read-latency counter registers.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept commands only in IDLE, count down the read latency, flag overruns.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    drop    = 1'b0;
    par_bad = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (upd) begin
          if (!par_ok) begin
            par_bad = 1'b1;
          end else if (cmd.wr) begin
            acc_wr  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            acc_rd  = 1'b1;
            cnt_d   = CNT_W'(READ_LATENCY);
            state_d = ST_READ_WAIT;
          end
        end
      end
      ST_WRITE: begin
        drop    = upd;
        state_d = ST_IDLE;
      end
      ST_READ_WAIT: begin
        drop = upd;
        if (cnt_q == '0) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign write = (state_q == ST_WRITE);
  assign busy  = (state_q != ST_IDLE);

  // DR shift register: capture loads status, shift moves toward tdo; held during update.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (cap) begin
      sr <= cap_word;
    end else if (shf) begin
      sr <= {tdi, sr[F-1:1]};
    end
  end

  // Sticky error/overrun flags, cleared when the host captures them.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (par_bad) begin
        err <= 1'b1;
      end else if (cap) begin
        err <= 1'b0;
      end
      if (drop) begin
        ovr <= 1'b1;
      end else if (cap) begin
        ovr <= 1'b0;
      end
    end
  end

  // Register-bank address/data outputs and the read-data buffer.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      wdata    <= '0;
      rd_buf   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (acc_wr) begin
        addr  <= cmd.addr;
        wdata <= cmd.data;
      end
      if (acc_rd) begin
        addr     <= cmd.addr;
        rd_valid <= 1'b0;
      end
      if (rd_done) begin
        rd_buf   <= rdata;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdlverifier_jtag_cmd_shifter.sv
// Bench for hdlverifier_jtag_cmd_shifter: directed command table, hand-written corner sequences,
// then random commands checked against a register-file model.
// The bank model below returns registered read data one cycle after addr.
`timescale 1ns/1ps
module tb_hdlverifier_jtag_cmd_shifter;

`ifdef HDLVERIFIER_JTAG_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int F  = 1 + AW + DW + PB;
  localparam int CW = DW + 3;

  logic          tck;
  logic          reset;
  logic          sel;
  logic          capture_dr;
  logic          shift_dr;
  logic          update_dr;
  logic          tdi;
  logic          tdo;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          write;
  logic [DW-1:0] rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  int            pulses = 0;
  logic [AW-1:0] pulse_addr;
  logic [DW-1:0] pulse_data;

  logic [DW-1:0] bank [32];
  bit            bank_vld [32];
  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] last_rd;
  bit            pend_ovr;

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vecs [11];

  hdlverifier_jtag_cmd_shifter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(2)
  ) dut (
    .tck       (tck),
    .reset     (reset),
    .sel       (sel),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .tdi       (tdi),
    .tdo       (tdo),
    .addr      (addr),
    .wdata     (wdata),
    .write     (write),
    .rdata     (rdata),
    .busy      (busy)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | {27'd0, a};
  endfunction

  // Register bank with one registered read stage.
  always @(posedge tck) begin
    if (write === 1'b1) begin
      bank[addr]     <= wdata;
      bank_vld[addr] <= 1'b1;
    end
    rdata <= bank_vld[addr] ? bank[addr] : init_val(addr);
  end

  // Count write-strobe cycles and remember what they carried.
  always @(negedge tck) begin
    if (write === 1'b1) begin
      pulses     = pulses + 1;
      pulse_addr = addr;
      pulse_data = wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [F-1:0] mk_frame(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [F-1:0] f;
    f = '0;
    f[0] = wr;
    f[AW:1] = a;
    f[AW+DW:AW+1] = d;
`ifdef HDLVERIFIER_JTAG_PARITY_EN
    f[F-1] = ^f[F-2:0];
`endif
    return f;
  endfunction

  task automatic shift_frame(input logic [F-1:0] f);
    for (int i = 0; i < F; i++) begin
      shift_dr = 1'b1;
      tdi = f[i];
      cyc();
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic do_update(input int n);
    update_dr = 1'b1;
    repeat (n) cyc();
    update_dr = 1'b0;
  endtask

  task automatic capture_read(output logic [CW-1:0] v);
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    tdi = 1'b0;
    for (int i = 0; i < CW; i++) begin
      v[i] = tdo;
      cyc();
    end
    shift_dr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    check("wait_idle_busy", 64'(busy), 64'd0);
  endtask

  // One full command; writes update the model, reads compare against exp_rd.
  task automatic run_cmd(input string nm, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input bit extra);
    int p0;
    logic [CW-1:0] cv;
    shift_frame(mk_frame(wr, a, d));
    p0 = pulses;
    do_update(extra ? 2 : 1);
    if (extra) pend_ovr = 1'b1;
    check({nm, "_addr"}, 64'(addr), 64'(a));
    wait_idle();
    cyc();
    if (wr) begin
      check({nm, "_pulses"}, 64'(pulses - p0), 64'd1);
      check({nm, "_waddr"}, 64'(pulse_addr), 64'(a));
      check({nm, "_wdata"}, 64'(pulse_data), 64'(d));
      exp_mem[a] = d;
    end else begin
      check({nm, "_nowrite"}, 64'(pulses - p0), 64'd0);
      capture_read(cv);
      check({nm, "_rdata"}, 64'(cv[DW-1:0]), 64'(exp_rd));
      check({nm, "_rdvalid"}, 64'(cv[DW]), 64'd1);
      check({nm, "_err"}, 64'(cv[DW+1]), 64'd0);
      check({nm, "_ovr"}, 64'(cv[DW+2]), 64'(pend_ovr));
      pend_ovr = 1'b0;
      last_rd = exp_rd;
    end
  endtask

  initial begin
    logic [CW-1:0] cv;
    logic [F-1:0]  fr;
    int            p0;
    logic          rwr;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    bit            rex;

    reset = 1'b0;
    sel = 1'b1;
    capture_dr = 1'b0;
    shift_dr = 1'b0;
    update_dr = 1'b0;
    tdi = 1'b0;
    pend_ovr = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 32; i++) exp_mem[i] = init_val(AW'(i));

    vecs[0]  = '{1'b1, 5'd3,  32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 5'd2,  32'h1234_5678, 32'h0};
    vecs[2]  = '{1'b0, 5'd2,  32'h0,         32'h1234_5678};
    vecs[3]  = '{1'b0, 5'd3,  32'h0,         32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 5'd5,  32'h0,         32'hA5A5_0005};
    vecs[5]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, 5'd31, 32'h0,         32'hFFFF_FFFF};
    vecs[7]  = '{1'b1, 5'd0,  32'h0000_0000, 32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         32'h0000_0000};
    vecs[9]  = '{1'b1, 5'd31, 32'h0000_0001, 32'h0};
    vecs[10] = '{1'b0, 5'd31, 32'h0,         32'h0000_0001};

    // Reset state
    repeat (3) cyc();
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    cyc();

    // Directed command table
    for (int i = 0; i < 11; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 1'b0);
    end

    // Reset in the middle of a shift discards everything
    fr = mk_frame(1'b1, 5'd3, 32'hDEAD_BEEF);
    for (int i = 0; i < 20; i++) begin
      shift_dr = 1'b1;
      tdi = fr[i];
      cyc();
    end
    reset = 1'b0;
    #1;
    check("midrst_tdo", 64'(tdo), 64'd0);
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_wdata", 64'(wdata), 64'd0);
    check("midrst_write", 64'(write), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    shift_dr = 1'b0;
    tdi = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    last_rd = '0;
    capture_read(cv);
    check("midrst_status", 64'(cv), 64'd0);
    run_cmd("post_rst_wr", 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0, 1'b0);

    // Plain read of address 2
    run_cmd("rd2", 1'b0, 5'd2, 32'h0, 32'h1234_5678, 1'b0);

    // Capture one cycle after a read update sees rd_valid=0 and stale data
    shift_frame(mk_frame(1'b0, 5'd3, 32'h0));
    do_update(1);
    capture_read(cv);
    check("early_rdvalid", 64'(cv[DW]), 64'd0);
    check("early_stale", 64'(cv[DW-1:0]), 64'(last_rd));
    wait_idle();
    capture_read(cv);
    check("retry_rdvalid", 64'(cv[DW]), 64'd1);
    check("retry_rdata", 64'(cv[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    last_rd = 32'hDEAD_BEEF;

    // Update one cycle after a read update is dropped and flagged
    shift_frame(mk_frame(1'b0, 5'd7, 32'h0));
    do_update(2);
    check("drop_addr", 64'(addr), 64'd7);
    check("drop_busy", 64'(busy), 64'd1);
    wait_idle();
    cyc();
    capture_read(cv);
    check("drop_ovr1", 64'(cv[DW+2]), 64'd1);
    check("drop_rdata", 64'(cv[DW-1:0]), 64'hA5A5_0007);
    capture_read(cv);
    check("drop_ovr0", 64'(cv[DW+2]), 64'd0);
    check("drop_rdvalid_kept", 64'(cv[DW]), 64'd1);

    // Update together with shift: update acts and the frame stays intact
    shift_frame(mk_frame(1'b1, 5'd10, 32'h0BAD_F00D));
    p0 = pulses;
    update_dr = 1'b1;
    shift_dr = 1'b1;
    tdi = 1'b1;
    cyc();
    update_dr = 1'b0;
    shift_dr = 1'b0;
    tdi = 1'b0;
    wait_idle();
    cyc();
    check("updshf_pulses", 64'(pulses - p0), 64'd1);
    check("updshf_addr", 64'(pulse_addr), 64'd10);
    check("updshf_data", 64'(pulse_data), 64'h0BAD_F00D);
    exp_mem[10] = 32'h0BAD_F00D;
    check("updshf_tdo", 64'(tdo), 64'd1);
    // Strobes with sel low change nothing
    p0 = pulses;
    sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      update_dr = 1'($urandom_range(0, 1));
      capture_dr = 1'($urandom_range(0, 1));
      shift_dr = 1'($urandom_range(0, 1));
      tdi = 1'($urandom_range(0, 1));
      cyc();
    end
    update_dr = 1'b0;
    capture_dr = 1'b0;
    shift_dr = 1'b0;
    tdi = 1'b0;
    sel = 1'b1;
    check("nosel_busy", 64'(busy), 64'd0);
    check("nosel_pulses", 64'(pulses - p0), 64'd0);
    check("nosel_tdo", 64'(tdo), 64'd1);
    do_update(1);
    wait_idle();
    cyc();
    check("repeat_pulses", 64'(pulses - p0), 64'd1);
    check("repeat_addr", 64'(pulse_addr), 64'd10);
    check("repeat_data", 64'(pulse_data), 64'h0BAD_F00D);

`ifdef HDLVERIFIER_JTAG_PARITY_EN
    // Bad parity: no write, err reported and then cleared
    fr = mk_frame(1'b1, 5'd12, 32'hCAFE_F00D);
    fr[F-1] = ~fr[F-1];
    shift_frame(fr);
    p0 = pulses;
    do_update(1);
    check("par_busy", 64'(busy), 64'd0);
    cyc();
    check("par_nowrite", 64'(pulses - p0), 64'd0);
    capture_read(cv);
    check("par_err1", 64'(cv[DW+1]), 64'd1);
    run_cmd("par_ok_wr", 1'b1, 5'd12, 32'hCAFE_F00D, 32'h0, 1'b0);
    capture_read(cv);
    check("par_err0", 64'(cv[DW+1]), 64'd0);
`endif

    // Random commands against the register-file model
    for (int k = 0; k < 40; k++) begin
      rwr = 1'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 31));
      rd = $urandom;
      rex = ($urandom_range(0, 3) == 0);
      run_cmd($sformatf("rnd%0d", k), rwr, ra, rd, exp_mem[ra], rex);
      sel = 1'b0;
      repeat ($urandom_range(0, 4)) begin
        update_dr = 1'($urandom_range(0, 1));
        capture_dr = 1'($urandom_range(0, 1));
        shift_dr = 1'($urandom_range(0, 1));
        tdi = 1'($urandom_range(0, 1));
        cyc();
      end
      update_dr = 1'b0;
      capture_dr = 1'b0;
      shift_dr = 1'b0;
      tdi = 1'b0;
      sel = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
